// File: rtl/is_uart_tx.sv
// rtl/is_uart_tx.sv - UART serial transmitter with level-valid / pulse-ack byte intake
//
// Purpose:
//   Serialises bytes handed over by the controller FSM. Each frame is made of:
//     - a start bit (0);
//     - DATA_W data bits, LSB first;
//     - an optional parity bit;
//     - STOP_BITS stop bits (1).
//   Every bit lasts CLKS_PER_BIT clock cycles. A byte offered during the last
//   stop cycle is taken straight away, so back-to-back frames have no idle gap.
//
// Ports:
//   clk_i        in   system clock
//   rstn_i       in   asynchronous active-low reset
//   tx_rdy_t_i   in   byte valid (level, may stay high across bytes)
//   tx_data_t_i  in   byte to send, sampled only in the accept cycle
//   tx_rdy_r_o   out  one-cycle ack, high in the first cycle of the start bit
//   tx_o         out  serial line, idle high
//   busy_o       out  high from accept until the last stop cycle has completed

module is_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              tx_rdy_t_i,
  input  logic [DATA_W-1:0] tx_data_t_i,
  output logic              tx_rdy_r_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [BAUD_W-1:0]   baud_q;
  logic [CNT_W-1:0]    bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_q;
  logic                ack_q;
  logic                accept;
  logic                bit_end;
  logic                data_last;
  logic                stop_last;

  // bit_q counts data bits in DATA and completed stop bits in STOP.
  assign bit_end   = (baud_q == BAUD_LAST);
  assign data_last = bit_end && (bit_q == DATA_LAST);
  assign stop_last = bit_end && (bit_q == STOP_LAST);

  assign tx_rdy_r_o = ack_q;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A byte is accepted in IDLE or in the final stop cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_rdy_t_i) begin
          accept  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (data_last) state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (stop_last) begin
          if (tx_rdy_t_i) begin
            accept  = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. The line is driven from the state so that it falls on
  // the accept edge and snaps back high the instant reset asserts.
  always_comb begin
    tx_o   = 1'b1;
    busy_o = (state_q != S_IDLE);
    case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift_q[0];
      S_PAR:   tx_o = par_q;
      default: tx_o = 1'b1;
    endcase
  end

  // Datapath: baud/bit counters, shift register, parity and ack.
  // The frame is captured into shift_q/par_q on accept, so the data bus may
  // move freely afterwards.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        baud_q  <= '0;
        bit_q   <= '0;
        shift_q <= tx_data_t_i;
        par_q   <= (PARITY_ODD != 0) ? ~^tx_data_t_i : ^tx_data_t_i;
      end else if (state_q != S_IDLE) begin
        if (bit_end) begin
          baud_q <= '0;
          case (state_q)
            S_DATA: begin
              shift_q <= shift_q >> 1;
              bit_q   <= data_last ? '0 : bit_q + CNT_W'(1);
            end
            S_STOP: begin
              bit_q <= stop_last ? '0 : bit_q + CNT_W'(1);
            end
            default: ;
          endcase
        end else begin
          baud_q <= baud_q + BAUD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_is_uart_tx.sv
// tb/tb_is_uart_tx.sv - bench for is_uart_tx: no-parity, even and odd instances side by side
module tb_is_uart_tx;

  logic       clk;
  logic       rstn;
  logic       valid;
  logic [7:0] data;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] ack_v;

  int errors = 0;
  int checks = 0;

  // Instance 0: no parity; 1: even parity; 2: odd parity. Shared inputs.
  is_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .tx_rdy_t_i(valid), .tx_data_t_i(data),
    .tx_rdy_r_o(ack_v[0]), .tx_o(tx_v[0]), .busy_o(busy_v[0]));
  is_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .tx_rdy_t_i(valid), .tx_data_t_i(data),
    .tx_rdy_r_o(ack_v[1]), .tx_o(tx_v[1]), .busy_o(busy_v[1]));
  is_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk_i(clk), .rstn_i(rstn), .tx_rdy_t_i(valid), .tx_data_t_i(data),
    .tx_rdy_r_o(ack_v[2]), .tx_o(tx_v[2]), .busy_o(busy_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame length and line level t cycles after the start edge.
  function automatic int flen(int c);
    return (c == 0) ? 40 : 44;
  endfunction

  function automatic logic fbit(int c, logic [7:0] b, int t);
    int idx;
    if (t < 0 || t >= flen(c)) return 1'b1;
    idx = t / 4;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (c != 0 && idx == 9) begin
      if (c == 1) return (($countones(b) % 2) == 1);
      return (($countones(b) % 2) == 0);
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    rstn  = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_v !== 3'b111 || busy_v !== 3'b000 || ack_v !== 3'b000) begin
      errors++;
      $display("FAIL reset tx=%b busy=%b ack=%b want 111/000/000", tx_v, busy_v, ack_v);
    end
    rstn = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      checks++;
      if (tx_v !== 3'b111 || busy_v !== 3'b000 || ack_v !== 3'b000) begin
        errors++;
        $display("FAIL idle t=%0d tx=%b busy=%b ack=%b want 111/000/000", t, tx_v, busy_v, ack_v);
      end
    end
  endtask

  // Single frames, valid for one cycle: fixed patterns then random bytes.
  task automatic test_frames();
    logic [7:0] list[$];
    logic [7:0] b;
    logic [2:0] etx, ebusy, eack;
    list = '{8'h0D, 8'h41, 8'h00, 8'hFF};
    for (int k = 0; k < 5; k++) list.push_back(8'($urandom_range(0, 255)));
    for (int k = 0; k < list.size(); k++) begin
      b     = list[k];
      valid = 1'b1;
      data  = b;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
          etx[c]   = fbit(c, b, t);
          ebusy[c] = (t < flen(c));
          eack[c]  = (t == 0);
        end
        checks++;
        if (tx_v !== etx) begin
          errors++;
          $display("FAIL frame byte=%h t=%0d tx got %b want %b", b, t, tx_v, etx);
        end
        checks++;
        if (busy_v !== ebusy || ack_v !== eack) begin
          errors++;
          $display("FAIL frame_hs byte=%h t=%0d busy/ack got %b/%b want %b/%b", b, t, busy_v, ack_v, ebusy, eack);
        end
        if (t == 0) begin
          valid = 1'b0;
          data  = 8'($urandom_range(0, 255));
        end
      end
    end
  endtask

  // Valid held across two bytes; the bus swaps to the second byte after the first ack.
  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    logic [2:0] etx, ebusy, eack;
    for (int k = 0; k < 3; k++) begin
      b0 = (k == 0) ? 8'h0D : 8'($urandom_range(0, 255));
      b1 = (k == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      valid = 1'b1;
      data  = b0;
      for (int t = 0; t < 96; t++) begin
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
          etx[c]   = (t < flen(c)) ? fbit(c, b0, t) : fbit(c, b1, t - flen(c));
          ebusy[c] = (t < 2 * flen(c));
          eack[c]  = (t == 0) || (t == flen(c));
        end
        checks++;
        if (tx_v !== etx) begin
          errors++;
          $display("FAIL b2b bytes=%h,%h t=%0d tx got %b want %b", b0, b1, t, tx_v, etx);
        end
        checks++;
        if (busy_v !== ebusy || ack_v !== eack) begin
          errors++;
          $display("FAIL b2b_hs t=%0d busy/ack got %b/%b want %b/%b", t, busy_v, ack_v, ebusy, eack);
        end
        if (t == 0)  data  = b1;
        if (t == 50) valid = 1'b0;
      end
    end
  endtask

  // Valid dropped mid-frame with the bus forced to FF: original byte completes, then idle.
  task automatic test_valid_drop();
    logic [7:0] b;
    logic [2:0] etx, ebusy, eack;
    b     = 8'h5C;
    valid = 1'b1;
    data  = b;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        etx[c]   = fbit(c, b, t);
        ebusy[c] = (t < flen(c));
        eack[c]  = (t == 0);
      end
      checks++;
      if (tx_v !== etx || busy_v !== ebusy || ack_v !== eack) begin
        errors++;
        $display("FAIL drop t=%0d tx/busy/ack got %b/%b/%b want %b/%b/%b",
                 t, tx_v, busy_v, ack_v, etx, ebusy, eack);
      end
      if (t == 10) begin
        valid = 1'b0;
        data  = 8'hFF;
      end
    end
  endtask

  // Reset asserted 17 cycles into a frame, then a clean frame afterwards.
  task automatic test_reset_mid();
    logic [7:0] b;
    logic [2:0] etx, ebusy, eack;
    valid = 1'b1;
    data  = 8'hA7;
    for (int t = 0; t < 17; t++) begin
      @(negedge clk);
      if (t == 0) valid = 1'b0;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (tx_v !== 3'b111 || busy_v !== 3'b000 || ack_v !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid tx=%b busy=%b ack=%b want 111/000/000", tx_v, busy_v, ack_v);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    b     = 8'($urandom_range(0, 255));
    valid = 1'b1;
    data  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        etx[c]   = fbit(c, b, t);
        ebusy[c] = (t < flen(c));
        eack[c]  = (t == 0);
      end
      checks++;
      if (tx_v !== etx || busy_v !== ebusy || ack_v !== eack) begin
        errors++;
        $display("FAIL after_reset byte=%h t=%0d tx/busy/ack got %b/%b/%b want %b/%b/%b",
                 b, t, tx_v, busy_v, ack_v, etx, ebusy, eack);
      end
      if (t == 0) valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_valid_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
